// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG health monitor: FSM state encoding,
// default test cutoffs and the counter-width helper.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_RUN     = 2'd2,
        ST_FAIL    = 2'd3
    } hm_state_e;

    localparam int RCT_C     = 32;    // consecutive identical bits that trip the RCT
    localparam int APT_W     = 512;   // APT window length in valid samples
    localparam int APT_C     = 410;   // matches to the window's first bit that trip the APT
    localparam int STARTUP_N = 1024;  // clean samples required before forwarding

    // Counters run up to their limit inclusive, so they need room for the limit itself.
    function automatic int cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/trng_health_mon_if.sv
// Raw and forwarded bit streams of the TRNG health monitor.
// master: entropy-source / downstream side, slave: the monitor.
interface trng_health_mon_if;

    logic raw_val;
    logic raw_rnb;
    logic out_val;
    logic out_rnb;

    modport master (output raw_val, output raw_rnb, input out_val, input out_rnb);
    modport slave  (input raw_val, input raw_rnb, output out_val, output out_rnb);

endinterface

// File: rtl/trng_apt_win.sv
// Adaptive-proportion test window: tracks the window index, the reference
// bit latched at index 0 and the number of samples matching it. 'hit' flags
// the sample that brings the match count up to the cutoff.
module trng_apt_win #(
    parameter int APT_W = trng_pkg::APT_W,
    parameter int APT_C = trng_pkg::APT_C
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic smp,
    input  logic smp_bit,
    output logic hit
);
    import trng_pkg::*;

    localparam int IDX_W   = cnt_w(APT_W);
    localparam int MATCH_W = cnt_w(APT_C);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(APT_W - 1);
    localparam logic [MATCH_W-1:0] MATCH_CUT = MATCH_W'(APT_C);

    logic [IDX_W-1:0]   win_idx;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_nxt;
    logic               ref_bit;
    logic               matched;

    // Match count after this sample; only a counting sample can land on the cutoff.
    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        match_nxt = match_cnt;
        matched   = 1'b0;
        if (win_idx == '0) begin
            match_nxt = MATCH_W'(1);
            matched   = 1'b1;
        end else if (smp_bit == ref_bit) begin
            match_nxt = match_cnt + MATCH_W'(1);
            matched   = 1'b1;
        end
        hit = smp && matched && (match_nxt == MATCH_CUT);
    end

    // Window bookkeeping; the window wraps after index APT_W-1 with nothing carried over.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            win_idx   <= '0;
            match_cnt <= '0;
            ref_bit   <= 1'b0;
        end else if (clr) begin
            win_idx   <= '0;
            match_cnt <= '0;
            ref_bit   <= 1'b0;
        end else if (smp) begin
            if (win_idx == '0)
                ref_bit <= smp_bit;
            match_cnt <= match_nxt;
            win_idx   <= (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/trng_health_mon.sv
// TRNG online health monitor: repetition-count and adaptive-proportion tests
// on the raw bit stream, start-up gating, sticky alarms and a registered
// forwarding stage toward the parity post-filter.
// Optional build macro TRNG_HM_CNT_EN adds fail_cnt, a saturating count of
// FAIL entries that only reset clears.
module trng_health_mon #(
    parameter int RCT_C     = trng_pkg::RCT_C,
    parameter int APT_W     = trng_pkg::APT_W,
    parameter int APT_C     = trng_pkg::APT_C,
    parameter int STARTUP_N = trng_pkg::STARTUP_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr_alarm,
    trng_health_mon_if.slave        bus,
    output logic                    alarm_rct,
    output logic                    alarm_apt,
    output logic                    healthy
`ifdef TRNG_HM_CNT_EN
    ,
    output logic [15:0]             fail_cnt
`endif
);
    import trng_pkg::*;

    localparam int REP_W  = cnt_w(RCT_C);
    localparam int SAMP_W = cnt_w(STARTUP_N);
    localparam logic [REP_W-1:0]  REP_CUT   = REP_W'(RCT_C);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(STARTUP_N - 1);

    hm_state_e         state;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_nxt;
    logic [SAMP_W-1:0] samp_cnt;
    logic              last_bit;
    logic              consume;
    logic              cnt_clr;
    logic              rct_hit;
    logic              apt_hit;
    logic              any_hit;
    logic              startup_done;
    logic              fwd_val;

    // Samples only count while testing; counters sit cleared for the whole IDLE stay.
    assign consume      = bus.raw_val && (state == ST_STARTUP || state == ST_RUN);
    assign cnt_clr      = (state == ST_IDLE);
    assign any_hit      = rct_hit || apt_hit;
    assign startup_done = consume && (state == ST_STARTUP) && (samp_cnt == SAMP_LAST);
    assign fwd_val      = consume && (state == ST_RUN) && !any_hit;

    // Run length including the current sample; a fresh run (or first sample) restarts at 1.
    always_comb begin
        rep_nxt = REP_W'(1);
        if (rep_cnt != '0 && bus.raw_rnb == last_bit)
            rep_nxt = (rep_cnt == REP_CUT) ? REP_CUT : rep_cnt + REP_W'(1);
        rct_hit = consume && (rep_nxt == REP_CUT);
    end

    trng_apt_win #(
        .APT_W (APT_W),
        .APT_C (APT_C)
    ) u_apt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .smp     (consume),
        .smp_bit (bus.raw_rnb),
        .hit     (apt_hit)
    );

    // RCT run tracking and the start-up sample count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt  <= '0;
            last_bit <= 1'b0;
            samp_cnt <= '0;
        end else if (cnt_clr) begin
            rep_cnt  <= '0;
            last_bit <= 1'b0;
            samp_cnt <= '0;
        end else if (consume) begin
            rep_cnt  <= rep_nxt;
            last_bit <= bus.raw_rnb;
            if (state == ST_STARTUP)
                samp_cnt <= samp_cnt + SAMP_W'(1);
        end
    end

    // Health FSM with registered healthy/alarm outputs and the forwarding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            healthy     <= 1'b0;
            alarm_rct   <= 1'b0;
            alarm_apt   <= 1'b0;
            bus.out_val <= 1'b0;
            bus.out_rnb <= 1'b0;
        end else begin
            bus.out_val <= fwd_val;
            bus.out_rnb <= fwd_val && bus.raw_rnb;
            case (state)
                ST_IDLE: begin
                    if (en)
                        state <= ST_STARTUP;
                end
                ST_STARTUP, ST_RUN: begin
                    if (any_hit) begin
                        state   <= ST_FAIL;
                        healthy <= 1'b0;
                    end else if (!en) begin
                        state   <= ST_IDLE;
                        healthy <= 1'b0;
                    end else if (startup_done) begin
                        state   <= ST_RUN;
                        healthy <= 1'b1;
                    end
                end
                ST_FAIL: begin
                    if (clr_alarm) begin
                        state     <= ST_IDLE;
                        alarm_rct <= 1'b0;
                        alarm_apt <= 1'b0;
                    end
                end
            endcase
            // Placed last so a fresh alarm overrides a clear in the same cycle.
            if (rct_hit)
                alarm_rct <= 1'b1;
            if (apt_hit)
                alarm_apt <= 1'b1;
        end
    end

`ifdef TRNG_HM_CNT_EN
    // Saturating count of FAIL entries; clr_alarm does not touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fail_cnt <= '0;
        else if (any_hit && fail_cnt != 16'hFFFF)
            fail_cnt <= fail_cnt + 16'd1;
    end
`endif

endmodule
